// File: rtl/accel_poll_sequencer_pkg.sv
// Shared types and constants for the accelerometer poll sequencer and its
// single-transfer AHB master.
package accel_poll_sequencer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [3:0] OFF_SPICON = 4'h0;
    localparam logic [3:0] OFF_TX     = 4'h4;
    localparam logic [3:0] OFF_RX     = 4'h8;

    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] AXIS_REG_X = 8'h08;
    localparam logic [7:0] AXIS_REG_Y = 8'h09;
    localparam logic [7:0] AXIS_REG_Z = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_ON, S_TX_CMD, S_POLL_CMD, S_TX_ADDR, S_POLL_ADDR,
        S_TX_DUMMY, S_POLL_DUMMY, S_RD_RX, S_CS_OFF, S_ABORT
    } seq_state_e;

    typedef enum logic [1:0] {X_IDLE, X_ADDR, X_DATA} xfer_phase_e;

    typedef struct packed {
        logic       req;
        logic       write;
        logic [3:0] off;
        logic [7:0] wbyte;
    } xfer_req_t;

    function automatic logic [7:0] axis_reg(input logic [1:0] axis);
        case (axis)
            2'd0:    return AXIS_REG_X;
            2'd1:    return AXIS_REG_Y;
            default: return AXIS_REG_Z;
        endcase
    endfunction

    // Successor along the fixed per-axis chain; poll exits and CS_OFF are
    // decided by the sequencer itself.
    function automatic seq_state_e seq_next(input seq_state_e s);
        case (s)
            S_CS_ON:      return S_TX_CMD;
            S_TX_CMD:     return S_POLL_CMD;
            S_POLL_CMD:   return S_TX_ADDR;
            S_TX_ADDR:    return S_POLL_ADDR;
            S_POLL_ADDR:  return S_TX_DUMMY;
            S_TX_DUMMY:   return S_POLL_DUMMY;
            S_POLL_DUMMY: return S_RD_RX;
            S_RD_RX:      return S_CS_OFF;
            default:      return S_IDLE;
        endcase
    endfunction

    // Bus transfer issued while sitting in a given state.
    function automatic xfer_req_t xfer_for(input seq_state_e s, input logic [1:0] axis);
        xfer_req_t r;
        r.req   = 1'b1;
        r.write = 1'b1;
        r.off   = OFF_SPICON;
        r.wbyte = 8'h00;
        case (s)
            S_IDLE:     r.req = 1'b0;
            S_CS_ON:    r.wbyte = 8'h01;
            S_TX_CMD:   begin r.off = OFF_TX; r.wbyte = CMD_READ; end
            S_TX_ADDR:  begin r.off = OFF_TX; r.wbyte = axis_reg(axis); end
            S_TX_DUMMY: r.off = OFF_TX;
            S_POLL_CMD, S_POLL_ADDR, S_POLL_DUMMY: r.write = 1'b0;
            S_RD_RX:    begin r.write = 1'b0; r.off = OFF_RX; end
            default:    r.wbyte = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/accel_poll_sequencer_xfer.sv
// Single non-pipelined AHB master transfer: one address phase, then a data
// phase held until HREADY. A new request may launch as the data phase ends.
module ahb_single_xfer
    import accel_poll_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h5000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY
);

    xfer_phase_e phase_q, phase_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_hold_q, wdata_hold_d;
    logic        launch;

    assign ack    = (phase_q == X_DATA) && HREADY;
    assign rdata  = HRDATA;
    assign launch = req && ((phase_q == X_IDLE) || ack);

    always_comb begin
        phase_d      = phase_q;
        haddr_d      = haddr_q;
        htrans_d     = htrans_q;
        hwrite_d     = hwrite_q;
        hwdata_d     = hwdata_q;
        wdata_hold_d = wdata_hold_q;
        case (phase_q)
            X_ADDR: if (HREADY) begin
                phase_d  = X_DATA;
                htrans_d = HTRANS_IDLE;
                hwdata_d = hwrite_q ? wdata_hold_q : 32'h0;
            end
            X_DATA: if (HREADY) begin
                phase_d  = X_IDLE;
                hwdata_d = 32'h0;
            end
            default: ;
        endcase
        if (launch) begin
            phase_d      = X_ADDR;
            htrans_d     = HTRANS_NONSEQ;
            haddr_d      = addr;
            hwrite_d     = write;
            wdata_hold_d = wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            phase_q      <= X_IDLE;
            haddr_q      <= RESET_ADDR;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            hwdata_q     <= 32'h0;
            wdata_hold_q <= 32'h0;
        end else begin
            phase_q      <= phase_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            hwdata_q     <= hwdata_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HWDATA = hwdata_q;

endmodule

// File: rtl/accel_poll_sequencer.sv
// Reads accelerometer X, Y, Z bytes through an AHB SPI master, polling the
// SPI busy flag after every byte and aborting if it never clears.
//
// state        | meaning
// S_IDLE       | waiting for start
// S_CS_ON      | write 1 to SPICON (chip select on)
// S_TX_CMD     | write read command 0x0B to TX
// S_POLL_*     | read SPICON until bit 7 clears, bounded by POLL_LIMIT
// S_TX_ADDR    | write axis register address to TX
// S_TX_DUMMY   | write 0x00 to TX to clock the answer in
// S_RD_RX      | read RX, capture axis byte
// S_CS_OFF     | write 0 to SPICON, next axis or finish
// S_ABORT      | poll timeout: write 0 to SPICON, flag error, finish
module accel_poll_sequencer
    import accel_poll_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter logic [7:0]  POLL_LIMIT = 8'd64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  accel_x,
    output logic [7:0]  accel_y,
    output logic [7:0]  accel_z
);

    seq_state_e state_q, state_d;
    logic [1:0] axis_q, axis_d;
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [7:0] accel_x_q, accel_x_d;
    logic [7:0] accel_y_q, accel_y_d;
    logic [7:0] accel_z_q, accel_z_d;

    xfer_req_t   xf;
    logic        ack;
    logic [31:0] rdata;
    logic        unused_rdata_hi;

    assign unused_rdata_hi = ^rdata[31:8];

    always_comb begin
        state_d    = state_q;
        axis_d     = axis_q;
        poll_cnt_d = poll_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        accel_x_d  = accel_x_q;
        accel_y_d  = accel_y_q;
        accel_z_d  = accel_z_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_CS_ON;
                axis_d     = 2'd0;
                poll_cnt_d = 8'd0;
                busy_d     = 1'b1;
                error_d    = 1'b0;
            end
            S_POLL_CMD, S_POLL_ADDR, S_POLL_DUMMY: if (ack) begin
                if (!rdata[7]) begin
                    state_d    = seq_next(state_q);
                    poll_cnt_d = 8'd0;
                end else if (({1'b0, poll_cnt_q} + 9'd1) == {1'b0, POLL_LIMIT}) begin
                    state_d    = S_ABORT;
                    poll_cnt_d = 8'd0;
                end else begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                end
            end
            S_RD_RX: if (ack) begin
                case (axis_q)
                    2'd0:    accel_x_d = rdata[7:0];
                    2'd1:    accel_y_d = rdata[7:0];
                    default: accel_z_d = rdata[7:0];
                endcase
                state_d = S_CS_OFF;
            end
            S_CS_OFF: if (ack) begin
                if (axis_q == 2'd2) begin
                    state_d = S_IDLE;
                    axis_d  = 2'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_CS_ON;
                    axis_d  = axis_q + 2'd1;
                end
            end
            S_ABORT: if (ack) begin
                state_d = S_IDLE;
                axis_d  = 2'd0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                error_d = 1'b1;
            end
            default: if (ack) state_d = seq_next(state_q);
        endcase
        // Request comes from the next state so a transfer can launch in the
        // same edge that retires the previous one (2 cycles per transfer).
        xf = xfer_for(state_d, axis_d);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            axis_q     <= 2'd0;
            poll_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            accel_x_q  <= 8'd0;
            accel_y_q  <= 8'd0;
            accel_z_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            axis_q     <= axis_d;
            poll_cnt_q <= poll_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            accel_x_q  <= accel_x_d;
            accel_y_q  <= accel_y_d;
            accel_z_q  <= accel_z_d;
        end
    end

    ahb_single_xfer #(.RESET_ADDR(BASE_ADDR)) u_xfer (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .req    (xf.req),
        .addr   (BASE_ADDR + {28'd0, xf.off}),
        .write  (xf.write),
        .wdata  ({24'd0, xf.wbyte}),
        .ack    (ack),
        .rdata  (rdata),
        .HADDR  (HADDR),
        .HTRANS (HTRANS),
        .HWRITE (HWRITE),
        .HWDATA (HWDATA),
        .HRDATA (HRDATA),
        .HREADY (HREADY)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign accel_x = accel_x_q;
    assign accel_y = accel_y_q;
    assign accel_z = accel_z_q;

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Bench for accel_poll_sequencer: behavioural SPI-master slave on AHB, with
// the expected bus transaction list built from the per-axis read recipe.
module tb_accel_poll_sequencer;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam logic [31:0] A_CON = BASE;
    localparam logic [31:0] A_TX  = BASE + 32'h4;
    localparam logic [31:0] A_RX  = BASE + 32'h8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY = 1'b1;
    logic        busy, done, error;
    logic [7:0]  accel_x, accel_y, accel_z;

    always #5 HCLK = ~HCLK;

    accel_poll_sequencer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY),
        .busy(busy), .done(done), .error(error),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z)
    );

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    bus_t log_q[$];
    bus_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SPI master model
    int          busy_polls = 0;
    bit          busy_forever = 1'b0;
    int          spi_left = 0;
    int          sel = 0;
    logic [7:0]  axis_val [3];
    logic [23:0] rx_hi = 24'h0;
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;

    always_comb begin
        HRDATA = 32'h0;
        if (dp_valid && !dp_write) begin
            if (dp_addr == A_CON)
                HRDATA = {rx_hi, (busy_forever || spi_left > 0), 7'h2A};
            else if (dp_addr == A_RX)
                HRDATA = {rx_hi, axis_val[sel]};
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 32'h0;
            spi_left <= 0;
        end else if (HREADY) begin
            if (dp_valid) begin
                log_q.push_back({dp_write, dp_addr, dp_write ? HWDATA : 32'h0});
                if (dp_write && dp_addr == A_TX) begin
                    spi_left <= busy_polls;
                    if (HWDATA[7:0] >= 8'h08 && HWDATA[7:0] <= 8'h0A)
                        sel <= int'(HWDATA[7:0]) - 8;
                end
                if (!dp_write && dp_addr == A_CON && spi_left > 0)
                    spi_left <= spi_left - 1;
            end
            dp_valid <= (HTRANS == 2'b10);
            dp_write <= HWRITE;
            dp_addr  <= HADDR;
        end
    end

    // HREADY driver, protocol monitor and directed data-phase stall
    int          wait_pct = 0;
    int          stall_cnt = 0;
    bit          stall_arm = 1'b0;
    logic [31:0] stall_ref = 32'h0;
    int          proto_err = 0;
    int          done_cnt = 0;

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (dp_valid && HTRANS != 2'b00) proto_err++;
            if (!(dp_valid && dp_write) && HWDATA != 32'h0) proto_err++;
            if (dp_valid && dp_write && HWDATA[31:8] != 24'h0) proto_err++;
            if (done && busy) proto_err++;
            if (done) done_cnt++;
        end
        if (stall_cnt > 0) begin
            check_val("stall_hwdata", HWDATA, stall_ref);
            check_val("stall_htrans", 32'(HTRANS), 32'h0);
            stall_cnt--;
            HREADY = (stall_cnt == 0);
        end else if (stall_arm && dp_valid && dp_write && dp_addr == A_TX) begin
            stall_arm = 1'b0;
            stall_ref = HWDATA;
            stall_cnt = 3;
            HREADY    = 1'b0;
        end else begin
            HREADY = ($urandom_range(0, 99) >= wait_pct);
        end
    end

    logic [7:0] exp_x = 8'h0, exp_y = 8'h0, exp_z = 8'h0;
    logic       exp_err = 1'b0;

    task automatic push_exp(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({w, a, d});
    endtask

    task automatic push_poll(input int polls);
        repeat (polls + 1) push_exp(1'b0, A_CON, 32'h0);
    endtask

    // Expected transfer list from the read-register recipe per axis.
    task automatic build_exp(input int polls, input bit fb);
        exp_q.delete();
        for (int ax = 0; ax < 3; ax++) begin
            push_exp(1'b1, A_CON, 32'h1);
            push_exp(1'b1, A_TX, 32'h0B);
            if (fb) begin
                repeat (64) push_exp(1'b0, A_CON, 32'h0);
                push_exp(1'b1, A_CON, 32'h0);
                return;
            end
            push_poll(polls);
            push_exp(1'b1, A_TX, 32'(8 + ax));
            push_poll(polls);
            push_exp(1'b1, A_TX, 32'h0);
            push_poll(polls);
            push_exp(1'b0, A_RX, 32'h0);
            push_exp(1'b1, A_CON, 32'h0);
        end
    endtask

    task automatic run_seq(input logic [7:0] vx, input logic [7:0] vy, input logic [7:0] vz,
                           input int polls, input bit fb, input int wpct,
                           input bit repulse, input bit arm_stall);
        int   n;
        bus_t g, e;
        axis_val[0] = vx; axis_val[1] = vy; axis_val[2] = vz;
        busy_polls = polls; busy_forever = fb; wait_pct = wpct; stall_arm = arm_stall;
        rx_hi = 24'($urandom);
        build_exp(polls, fb);
        log_q.delete();
        done_cnt = 0;
        proto_err = 0;
        @(negedge HCLK); start = 1'b1;
        @(negedge HCLK); start = 1'b0;
        check_val("busy_after_start", 32'(busy), 32'h1);
        check_val("error_cleared", 32'(error), 32'h0);
        n = 0;
        while (!done && n < 4000) begin
            start = (repulse && n == 10);
            @(negedge HCLK);
            n++;
        end
        start = 1'b0;
        check_val("done_seen", 32'(done), 32'h1);
        check_val("busy_at_done", 32'(busy), 32'h0);
        if (wpct == 0 && !arm_stall)
            check_val("latency", 32'(n), 32'(2 * exp_q.size()));
        repeat (12) @(negedge HCLK);
        if (!fb) begin exp_x = vx; exp_y = vy; exp_z = vz; end
        exp_err = fb;
        check_val("log_len", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            g = log_q[i];
            e = exp_q[i];
            if (g != e) begin
                check_val($sformatf("log[%0d].write", i), 32'(g.w), 32'(e.w));
                check_val($sformatf("log[%0d].addr", i), g.a, e.a);
                check_val($sformatf("log[%0d].wdata", i), g.d, e.d);
                break;
            end
        end
        check_val("accel_x", 32'(accel_x), 32'(exp_x));
        check_val("accel_y", 32'(accel_y), 32'(exp_y));
        check_val("accel_z", 32'(accel_z), 32'(exp_z));
        check_val("error", 32'(error), 32'(exp_err));
        check_val("done_pulses", 32'(done_cnt), 32'h1);
        check_val("busy_idle", 32'(busy), 32'h0);
        check_val("protocol", 32'(proto_err), 32'h0);
        if (arm_stall) check_val("stall_fired", 32'(stall_arm), 32'h0);
    endtask

    task automatic run_reset_mid();
        int n;
        busy_polls = 2; busy_forever = 1'b0; wait_pct = 0; stall_arm = 1'b0;
        @(negedge HCLK); start = 1'b1;
        @(negedge HCLK); start = 1'b0;
        n = 0;
        while (!(dp_valid && dp_write && dp_addr == A_TX && HWDATA == 32'h8) && n < 500) begin
            @(negedge HCLK);
            n++;
        end
        check_val("reached_tx_addr", HWDATA, 32'h8);
        HRESETn = 1'b0;
        #1;
        check_val("rst_mid_htrans", 32'(HTRANS), 32'h0);
        check_val("rst_mid_busy", 32'(busy), 32'h0);
        check_val("rst_mid_hwdata", HWDATA, 32'h0);
        check_val("rst_mid_accel_x", 32'(accel_x), 32'h0);
        exp_x = 8'h0; exp_y = 8'h0; exp_z = 8'h0; exp_err = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
    endtask

    initial begin
        repeat (3) @(negedge HCLK);
        check_val("rst_htrans", 32'(HTRANS), 32'h0);
        check_val("rst_hwrite", 32'(HWRITE), 32'h0);
        check_val("rst_haddr", HADDR, BASE);
        check_val("rst_hwdata", HWDATA, 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        check_val("rst_error", 32'(error), 32'h0);
        check_val("rst_accel", {8'h0, accel_x, accel_y, accel_z}, 32'h0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        run_seq(8'h12, 8'h34, 8'h56, 3, 1'b0, 0, 1'b0, 1'b0);
        run_seq(8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0, 0, 1'b0, 1'b1);
        run_seq(8'($urandom), 8'($urandom), 8'($urandom), 2, 1'b0, 0, 1'b1, 1'b0);
        run_seq(8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b1, 0, 1'b0, 1'b0);
        run_seq(8'($urandom), 8'($urandom), 8'($urandom), 63, 1'b0, 0, 1'b0, 1'b0);
        run_reset_mid();
        run_seq(8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            run_seq(8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 5)), 1'b0, int'($urandom_range(0, 30)), 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
